// File: rtl/digit_scan.sv
// Six-digit seven-segment scan controller; outputs are a pure mux of idx/active, no added latency.
// Loads are double-buffered and applied only at the frame wrap, so every frame shows one value.
module digit_scan #(
  parameter int DIV_CNT = 50000,
  parameter bit LZB_EN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] data_in,
  input  logic [5:0]  en_in,
  input  logic        load,
  output logic [3:0]  data_disp,
  output logic [2:0]  ctrl,
  output logic        upd_pend,
  output logic        frame_start
);

  localparam int            CW      = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   act_data_q, act_data_d;
  logic [5:0]    act_en_q, act_en_d;
  logic [23:0]   pend_data_q, pend_data_d;
  logic [5:0]    pend_en_q, pend_en_d;
  logic          upd_pend_q, upd_pend_d;
  logic          frame_start_q, frame_start_d;
  logic          tick, wrap;
  logic [5:0]    blank;
  logic          zero_above;
  logic [3:0]    nib;
  logic          shown;

  always_comb begin
    tick          = (cnt_q == CNT_MAX);
    wrap          = tick && (idx_q == 3'd5);
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    act_data_d    = act_data_q;
    act_en_d      = act_en_q;
    pend_data_d   = pend_data_q;
    pend_en_d     = pend_en_q;
    upd_pend_d    = upd_pend_q;
    frame_start_d = wrap;
    // Transfer uses the old pending value; a coincident load refills pending afterwards.
    if (wrap && upd_pend_q) begin
      act_data_d = pend_data_q;
      act_en_d   = pend_en_q;
      upd_pend_d = 1'b0;
    end
    if (load) begin
      pend_data_d = data_in;
      pend_en_d   = en_in;
      upd_pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      act_data_q    <= 24'd0;
      act_en_q      <= 6'b111111;
      pend_data_q   <= 24'd0;
      pend_en_q     <= 6'b111111;
      upd_pend_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_data_q    <= act_data_d;
      act_en_q      <= act_en_d;
      pend_data_q   <= pend_data_d;
      pend_en_q     <= pend_en_d;
      upd_pend_q    <= upd_pend_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Digit i is leading-blanked when nibbles i..5 are all zero; digit 0 always shows.
  always_comb begin
    blank      = 6'b000000;
    zero_above = 1'b1;
    if (LZB_EN) begin
      for (int i = 5; i >= 1; i--) begin
        zero_above = zero_above && (act_data_q[4*i +: 4] == 4'h0);
        blank[i]   = zero_above;
      end
    end
  end

  always_comb begin
    nib   = 4'h0;
    shown = 1'b0;
    case (idx_q)
      3'd0: begin nib = act_data_q[3:0];   shown = act_en_q[0] && !blank[0]; end
      3'd1: begin nib = act_data_q[7:4];   shown = act_en_q[1] && !blank[1]; end
      3'd2: begin nib = act_data_q[11:8];  shown = act_en_q[2] && !blank[2]; end
      3'd3: begin nib = act_data_q[15:12]; shown = act_en_q[3] && !blank[3]; end
      3'd4: begin nib = act_data_q[19:16]; shown = act_en_q[4] && !blank[4]; end
      3'd5: begin nib = act_data_q[23:20]; shown = act_en_q[5] && !blank[5]; end
      default: begin nib = 4'h0; shown = 1'b0; end
    endcase
  end

  assign data_disp   = nib;
  assign ctrl        = shown ? idx_q : 3'd7;
  assign upd_pend    = upd_pend_q;
  assign frame_start = frame_start_q;

endmodule
